// File: rtl/lsu_arbiter.sv
// Two-master arbiter for the single-port load/store unit.
// Owner FSM with bounded bursts and a last-served priority pointer.
module lsu_arbiter #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,

  input  logic        i_m0_req,
  input  logic        i_m0_wren,
  input  logic [31:0] i_m0_addr,
  input  logic [31:0] i_m0_wdata,
  output logic        o_m0_gnt,
  output logic        o_m0_rvalid,
  output logic [31:0] o_m0_rdata,

  input  logic        i_m1_req,
  input  logic        i_m1_wren,
  input  logic [31:0] i_m1_addr,
  input  logic [31:0] i_m1_wdata,
  output logic        o_m1_gnt,
  output logic        o_m1_rvalid,
  output logic [31:0] o_m1_rdata,

  output logic [31:0] o_lsu_addr,
  output logic [31:0] o_lsu_st_data,
  output logic        o_lsu_wren,
  input  logic [31:0] i_lsu_ld_data,

  output logic        o_busy
);

  localparam int unsigned CntW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CntW-1:0] LastBeat = CntW'(MAX_BURST - 1);

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

  state_e            state_q, state_d;
  logic              prio_q, prio_d;  // 0: master 0 wins a tie, 1: master 1
  logic [CntW-1:0]   beat_cnt_q, beat_cnt_d;
  logic              m0_rvalid_q, m0_rvalid_d;
  logic              m1_rvalid_q, m1_rvalid_d;
  logic [31:0]       m0_rdata_q, m0_rdata_d;
  logic [31:0]       m1_rdata_q, m1_rdata_d;

  logic gnt0, gnt1;

  // Grants follow req combinationally so a dropping req never gets a stray beat.
  assign gnt0 = (state_q == StOwn0) && i_m0_req;
  assign gnt1 = (state_q == StOwn1) && i_m1_req;

  assign o_m0_gnt    = gnt0;
  assign o_m1_gnt    = gnt1;
  assign o_m0_rvalid = m0_rvalid_q;
  assign o_m1_rvalid = m1_rvalid_q;
  assign o_m0_rdata  = m0_rdata_q;
  assign o_m1_rdata  = m1_rdata_q;
  assign o_busy      = (state_q != StIdle);

  always_comb begin
    o_lsu_addr    = '0;
    o_lsu_st_data = '0;
    o_lsu_wren    = 1'b0;
    if (gnt0) begin
      o_lsu_addr    = i_m0_addr;
      o_lsu_st_data = i_m0_wdata;
      o_lsu_wren    = i_m0_wren;
    end else if (gnt1) begin
      o_lsu_addr    = i_m1_addr;
      o_lsu_st_data = i_m1_wdata;
      o_lsu_wren    = i_m1_wren;
    end
  end

  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      StIdle: begin
        beat_cnt_d = '0;
        if (i_m0_req && i_m1_req) begin
          state_d = prio_q ? StOwn1 : StOwn0;
        end else if (i_m0_req) begin
          state_d = StOwn0;
        end else if (i_m1_req) begin
          state_d = StOwn1;
        end
      end
      StOwn0: begin
        if (!i_m0_req) begin
          state_d    = StIdle;
          prio_d     = 1'b1;
          beat_cnt_d = '0;
        end else if (beat_cnt_q == LastBeat) begin
          beat_cnt_d = '0;
          if (i_m1_req) begin
            state_d = StOwn1;
            prio_d  = 1'b1;
          end
        end else begin
          beat_cnt_d = beat_cnt_q + CntW'(1);
        end
      end
      StOwn1: begin
        if (!i_m1_req) begin
          state_d    = StIdle;
          prio_d     = 1'b0;
          beat_cnt_d = '0;
        end else if (beat_cnt_q == LastBeat) begin
          beat_cnt_d = '0;
          if (i_m0_req) begin
            state_d = StOwn0;
            prio_d  = 1'b0;
          end
        end else begin
          beat_cnt_d = beat_cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d    = StIdle;
        beat_cnt_d = '0;
      end
    endcase
  end

  // Load data is captured at the end of the granted read beat.
  always_comb begin
    m0_rvalid_d = gnt0 && !i_m0_wren;
    m1_rvalid_d = gnt1 && !i_m1_wren;
    m0_rdata_d  = m0_rvalid_d ? i_lsu_ld_data : m0_rdata_q;
    m1_rdata_d  = m1_rvalid_d ? i_lsu_ld_data : m1_rdata_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      prio_q      <= 1'b0;
      beat_cnt_q  <= '0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      beat_cnt_q  <= beat_cnt_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
    end
  end

endmodule

// File: tb/tb_lsu_arbiter.sv
// Bench for lsu_arbiter: two instances (MAX_BURST 4 and 1) against an ownership/memory model.
module tb_lsu_arbiter;

  localparam int NI = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mem_init;
  always #5 clk = ~clk;

  logic        req   [NI][2];
  logic        wren  [NI][2];
  logic [31:0] addr  [NI][2];
  logic [31:0] wdata [NI][2];
  logic        gnt   [NI][2];
  logic        rvalid[NI][2];
  logic [31:0] rdata [NI][2];
  logic [31:0] lsu_addr [NI];
  logic [31:0] lsu_st   [NI];
  logic        lsu_wren [NI];
  logic [31:0] ld_data  [NI];
  logic        busy     [NI];
  logic [31:0] mem      [NI][256];

  lsu_arbiter #(.MAX_BURST(4)) u_dut4 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_m0_req(req[0][0]), .i_m0_wren(wren[0][0]), .i_m0_addr(addr[0][0]),
    .i_m0_wdata(wdata[0][0]), .o_m0_gnt(gnt[0][0]), .o_m0_rvalid(rvalid[0][0]),
    .o_m0_rdata(rdata[0][0]),
    .i_m1_req(req[0][1]), .i_m1_wren(wren[0][1]), .i_m1_addr(addr[0][1]),
    .i_m1_wdata(wdata[0][1]), .o_m1_gnt(gnt[0][1]), .o_m1_rvalid(rvalid[0][1]),
    .o_m1_rdata(rdata[0][1]),
    .o_lsu_addr(lsu_addr[0]), .o_lsu_st_data(lsu_st[0]), .o_lsu_wren(lsu_wren[0]),
    .i_lsu_ld_data(ld_data[0]), .o_busy(busy[0])
  );

  lsu_arbiter #(.MAX_BURST(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_m0_req(req[1][0]), .i_m0_wren(wren[1][0]), .i_m0_addr(addr[1][0]),
    .i_m0_wdata(wdata[1][0]), .o_m0_gnt(gnt[1][0]), .o_m0_rvalid(rvalid[1][0]),
    .o_m0_rdata(rdata[1][0]),
    .i_m1_req(req[1][1]), .i_m1_wren(wren[1][1]), .i_m1_addr(addr[1][1]),
    .i_m1_wdata(wdata[1][1]), .o_m1_gnt(gnt[1][1]), .o_m1_rvalid(rvalid[1][1]),
    .o_m1_rdata(rdata[1][1]),
    .o_lsu_addr(lsu_addr[1]), .o_lsu_st_data(lsu_st[1]), .o_lsu_wren(lsu_wren[1]),
    .i_lsu_ld_data(ld_data[1]), .o_busy(busy[1])
  );

  function automatic logic [31:0] pattern(input int i);
    return (i == 0) ? 32'h0000_005A : 32'hA500_0000 + 32'(i) * 32'h0001_0203;
  endfunction

  // LSU stand-in: combinational load, store commits on the clock edge.
  assign ld_data[0] = mem[0][lsu_addr[0][9:2]];
  assign ld_data[1] = mem[1][lsu_addr[1][9:2]];

  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (mem_init) begin
        for (int i = 0; i < 256; i++) mem[k][i] <= pattern(i);
      end else if (lsu_wren[k]) begin
        mem[k][lsu_addr[k][9:2]] <= lsu_st[k];
      end
    end
  end

  // Reference model: who owns the LSU, how long they have held it, and memory contents.
  int          own    [NI];
  int          streak [NI];
  int          prio   [NI];
  logic        mrv    [NI][2];
  logic [31:0] mrd    [NI][2];
  logic        mg     [NI][2];
  logic [31:0] rmem   [NI][256];
  int          gcnt   [NI][2];

  int n_tests = 0;
  int n_fail  = 0;

  function automatic int burst_of(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_gnt(input int k, input int m);
    return (own[k] == m) && req[k][m];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      own[k] = -1; streak[k] = 0; prio[k] = 0;
      for (int m = 0; m < 2; m++) begin
        mrv[k][m] = 1'b0; mrd[k][m] = '0; mg[k][m] = 1'b0;
      end
    end
  endtask

  task automatic check_inst(input int k);
    logic        g0, g1, ew;
    logic [31:0] ea, ed;
    g0 = exp_gnt(k, 0);
    g1 = exp_gnt(k, 1);
    ea = '0; ed = '0; ew = 1'b0;
    if (g0) begin
      ea = addr[k][0]; ed = wdata[k][0]; ew = wren[k][0];
    end else if (g1) begin
      ea = addr[k][1]; ed = wdata[k][1]; ew = wren[k][1];
    end
    check($sformatf("i%0d gnt0", k), 32'(gnt[k][0]), 32'(g0));
    check($sformatf("i%0d gnt1", k), 32'(gnt[k][1]), 32'(g1));
    check($sformatf("i%0d busy", k), 32'(busy[k]), 32'(own[k] != -1));
    check($sformatf("i%0d lsu_wren", k), 32'(lsu_wren[k]), 32'(ew));
    check($sformatf("i%0d lsu_addr", k), lsu_addr[k], ea);
    check($sformatf("i%0d lsu_st", k), lsu_st[k], ed);
    for (int m = 0; m < 2; m++) begin
      check($sformatf("i%0d m%0d rvalid", k, m), 32'(rvalid[k][m]), 32'(mrv[k][m]));
      check($sformatf("i%0d m%0d rdata", k, m), rdata[k][m], mrd[k][m]);
    end
  endtask

  task automatic advance_inst(input int k);
    int x, idx;
    for (int m = 0; m < 2; m++) begin
      mg[k][m]  = exp_gnt(k, m);
      mrv[k][m] = 1'b0;
      if (mg[k][m]) begin
        idx = int'(addr[k][m][9:2]);
        if (wren[k][m]) begin
          rmem[k][idx] = wdata[k][m];
        end else begin
          mrv[k][m] = 1'b1;
          mrd[k][m] = rmem[k][idx];
        end
      end
    end
    if (own[k] == -1) begin
      streak[k] = 0;
      if (req[k][0] && req[k][1]) own[k] = prio[k];
      else if (req[k][0])         own[k] = 0;
      else if (req[k][1])         own[k] = 1;
    end else begin
      x = own[k];
      if (!req[k][x]) begin
        own[k] = -1; prio[k] = 1 - x; streak[k] = 0;
      end else begin
        streak[k]++;
        if ((streak[k] % burst_of(k)) == 0 && req[k][1 - x]) begin
          own[k] = 1 - x; prio[k] = 1 - x; streak[k] = 0;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < NI; k++) check_inst(k);
  endtask

  task automatic advance_all();
    for (int k = 0; k < NI; k++) advance_inst(k);
  endtask

  // Inputs change at posedge+1; outputs are checked and the model stepped at negedge.
  task automatic cycle();
    @(negedge clk);
    for (int k = 0; k < NI; k++)
      for (int m = 0; m < 2; m++)
        if (gnt[k][m] === 1'b1) gcnt[k][m]++;
    check_all();
    advance_all();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int k, input int m, input logic w, input logic [31:0] a,
                      input logic [31:0] d);
    logic seen;
    seen = 1'b0;
    req[k][m] = 1'b1; wren[k][m] = w; addr[k][m] = a; wdata[k][m] = d;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (mg[k][m]) begin
        seen = gnt[k][m] !== 1'b1 ? 1'b0 : 1'b1;
        break;
      end
    end
    check($sformatf("i%0d m%0d beat_done", k, m), 32'(mg[k][m]), 32'd1);
    req[k][m] = 1'b0;
  endtask

  task automatic gen_inst(input int k, input int p);
    for (int m = 0; m < 2; m++) begin
      if (req[k][m] && !mg[k][m]) continue;
      req[k][m]   = ($urandom_range(0, 99) < p);
      wren[k][m]  = 1'($urandom_range(0, 1));
      addr[k][m]  = ($urandom_range(0, 7) == 0) ? 32'h7800
                                                 : (32'h2000 | (32'($urandom_range(0, 15)) << 2));
      wdata[k][m] = $urandom;
    end
  endtask

  int c0, c1, b0, b1;

  initial begin
    mem_init = 1'b1;
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < 256; i++) rmem[k][i] = pattern(i);
      for (int m = 0; m < 2; m++) begin
        req[k][m] = 1'b0; wren[k][m] = 1'b0; addr[k][m] = '0; wdata[k][m] = '0;
        gcnt[k][m] = 0;
      end
    end
    model_reset();
    repeat (2) @(posedge clk);

    // Reset state, then both masters contend from the moment reset lifts.
    @(negedge clk);
    check_all();
    mem_init = 1'b0;
    for (int m = 0; m < 2; m++) begin
      req[0][m] = 1'b1; addr[0][m] = 32'h2010 + 32'(m) * 32'h10;
      req[1][m] = 1'b1; addr[1][m] = 32'h7800;
    end
    rst_n = 1'b1;
    advance_all();
    @(posedge clk);
    #1;
    repeat (20) cycle();
    check("i0 contention m0 beats", 32'(gcnt[0][0]), 32'd12);
    check("i0 contention m1 beats", 32'(gcnt[0][1]), 32'd8);
    check("i1 alternate m0 beats", 32'(gcnt[1][0]), 32'd10);
    check("i1 alternate m1 beats", 32'(gcnt[1][1]), 32'd10);
    check("i1 m0 switch data", rdata[1][0], 32'h0000_005A);
    check("i1 m1 switch data", rdata[1][1], 32'h0000_005A);
    for (int k = 0; k < NI; k++) for (int m = 0; m < 2; m++) req[k][m] = 1'b0;
    repeat (3) cycle();

    // Single write then read on master 0.
    beat(0, 0, 1'b1, 32'h2004, 32'hDEAD_BEEF);
    beat(0, 0, 1'b0, 32'h2004, 32'h0);
    cycle();
    check("m0 read back", rdata[0][0], 32'hDEAD_BEEF);
    repeat (2) cycle();

    // Reset asserted in the middle of a granted write.
    req[0][0] = 1'b1; wren[0][0] = 1'b1; addr[0][0] = 32'h2004; wdata[0][0] = 32'h1111_1111;
    for (int i = 0; i < 4; i++) begin
      if (exp_gnt(0, 0)) break;
      cycle();
    end
    #1;
    check("pre-reset gnt0", 32'(gnt[0][0]), 32'd1);
    check("pre-reset wren", 32'(lsu_wren[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      check($sformatf("i%0d rst wren", k), 32'(lsu_wren[k]), 32'd0);
      check($sformatf("i%0d rst addr", k), lsu_addr[k], 32'd0);
      check($sformatf("i%0d rst st", k), lsu_st[k], 32'd0);
      check($sformatf("i%0d rst busy", k), 32'(busy[k]), 32'd0);
      for (int m = 0; m < 2; m++) begin
        check($sformatf("i%0d rst gnt%0d", k, m), 32'(gnt[k][m]), 32'd0);
        check($sformatf("i%0d rst rvalid%0d", k, m), 32'(rvalid[k][m]), 32'd0);
        check($sformatf("i%0d rst rdata%0d", k, m), rdata[k][m], 32'd0);
      end
    end
    model_reset();
    addr[0][0] = 32'h2008; wdata[0][0] = 32'h2222_2222;
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
    advance_all();
    @(posedge clk);
    #1;
    beat(0, 0, 1'b1, 32'h2008, 32'h2222_2222);
    beat(0, 0, 1'b0, 32'h2004, 32'h0);
    cycle();
    check("aborted write not committed", rdata[0][0], 32'hDEAD_BEEF);
    beat(0, 0, 1'b0, 32'h2008, 32'h0);
    cycle();
    check("post-reset write", rdata[0][0], 32'h2222_2222);
    repeat (2) cycle();

    // Early release: M0 drops after two beats while M1 waits.
    req[0][0] = 1'b1; wren[0][0] = 1'b0; addr[0][0] = 32'h2004;
    wren[0][1] = 1'b0; addr[0][1] = 32'h2008;
    c0 = 0; c1 = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (mg[0][0]) c0++;
      if (mg[0][1]) c1++;
      if (c0 >= 1) req[0][1] = 1'b1;
      if (c0 == 2) req[0][0] = 1'b0;
      if (c1 == 2) req[0][1] = 1'b0;
    end
    b0 = gcnt[0][0];
    req[0][0] = 1'b1; req[0][1] = 1'b1;
    repeat (3) cycle();
    check("prio after release", 32'(gcnt[0][0] - b0), 32'd2);
    req[0][0] = 1'b0; req[0][1] = 1'b0;
    repeat (3) cycle();

    // Solo streaming on M1 across the burst counter wrap.
    b1 = gcnt[0][1];
    req[0][1] = 1'b1; wren[0][1] = 1'b0; addr[0][1] = 32'h2008;
    repeat (11) cycle();
    check("solo m1 beats", 32'(gcnt[0][1] - b1), 32'd10);
    req[0][1] = 1'b0;
    repeat (2) cycle();

    // Randomized traffic, heavy then light.
    for (int ph = 0; ph < 2; ph++) begin
      repeat (1500) begin
        cycle();
        for (int k = 0; k < NI; k++) gen_inst(k, (ph == 0) ? 85 : 35);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
